// File: rtl/elastic_pipe_reg.sv
// DEPTH-stage elastic register slice with valid/ready on both ends, flush and occupancy count.
// Latency DEPTH cycles unstalled; stalls hold data and bubbles collapse, o_ready falls only when full and i_ready=0.
module elastic_pipe_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_q,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_count
);

  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_dat [DEPTH];
  logic [CNT_W-1:0] r_count;

  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_in_vld;
  logic [WIDTH-1:0] w_in_dat [DEPTH];
  logic             w_accept;
  logic             w_pop;

  // A stage is ready if it or any stage downstream of it is empty, or the sink pops.
  always_comb begin : ready_chain
    logic v_any;
    v_any = i_ready;
    w_rdy = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      v_any    = v_any | ~r_vld[k];
      w_rdy[k] = v_any;
    end
  end

  assign o_ready  = w_rdy[0] & ~i_flush;
  assign w_accept = i_valid & o_ready;
  assign w_pop    = r_vld[DEPTH-1] & i_ready;

  always_comb begin
    w_in_vld    = '0;
    w_in_vld[0] = w_accept;
    w_in_dat[0] = i_d;
    for (int k = 1; k < DEPTH; k++) begin
      w_in_vld[k] = r_vld[k-1];
      w_in_dat[k] = r_dat[k-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld   <= '0;
      r_count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_dat[k] <= '0;
      end
    end else begin
      // Data only moves with a valid item, so bubbles and flushes leave it untouched.
      for (int k = 0; k < DEPTH; k++) begin
        if (w_rdy[k] && w_in_vld[k] && !i_flush) begin
          r_dat[k] <= w_in_dat[k];
        end
      end
      if (i_flush) begin
        r_vld   <= '0;
        r_count <= '0;
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (w_rdy[k]) begin
            r_vld[k] <= w_in_vld[k];
          end
        end
        if (w_accept && !w_pop) begin
          r_count <= r_count + CNT_W'(1);
        end else if (w_pop && !w_accept) begin
          r_count <= r_count - CNT_W'(1);
        end
      end
    end
  end

  assign o_valid = r_vld[DEPTH-1];
  assign o_q     = r_dat[DEPTH-1];
  assign o_count = r_count;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: directed scenarios plus random traffic against a queue-based timing model.
module tb_elastic_pipe_reg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             i_clk;
  logic             i_rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_d;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_q;
  logic             i_flush;
  logic [CNT_W-1:0] o_count;

  elastic_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_d     (i_d),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_q     (o_q),
    .i_flush (i_flush),
    .o_count (o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Model: FIFO of items with the edge they were accepted; an item reaches the
  // output DEPTH-1 edges after acceptance, or when its predecessor leaves.
  typedef struct {
    logic [WIDTH-1:0] dat;
    int               acc;
  } item_t;

  item_t q[$];
  int    cyc;
  int    last_dep;
  int    n_chk;
  int    n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
  endtask

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    logic exp_rdy;
    logic exp_vld;
    int   ha;
    i_valid = v;
    i_d     = d;
    i_ready = r;
    i_flush = f;
    #1;
    exp_rdy = !f && (q.size() < DEPTH || r);
    exp_vld = 1'b0;
    if (q.size() > 0) begin
      ha = q[0].acc + DEPTH - 1;
      if (last_dep > ha) ha = last_dep;
      exp_vld = (cyc >= ha);
    end
    chk("o_ready", 32'(o_ready), 32'(exp_rdy));
    chk("o_valid", 32'(o_valid), 32'(exp_vld));
    if (exp_vld) chk("o_q", 32'(o_q), 32'(q[0].dat));
    chk("o_count", 32'(o_count), 32'(q.size()));
    @(posedge i_clk);
    cyc++;
    if (f) begin
      q.delete();
    end else begin
      if (exp_vld && r) begin
        void'(q.pop_front());
        last_dep = cyc;
      end
      if (v && exp_rdy) q.push_back('{dat: d, acc: cyc});
    end
    @(negedge i_clk);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, '0, r, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; last_dep = 0;
    i_rst_n = 1'b0; i_valid = 1'b0; i_d = '0; i_ready = 1'b0; i_flush = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("reset_q", 32'(o_q), 32'h0);
    chk("reset_valid", 32'(o_valid), 32'h0);
    chk("reset_count", 32'(o_count), 32'h0);
    chk("reset_ready", 32'(o_ready), 32'h1);

    // Streaming at full rate
    for (int i = 1; i <= 16; i++) step(1'b1, WIDTH'(i), 1'b1, 1'b0);
    idle(6, 1'b1);

    // Backpressure with gaps collapsing into the top stages
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    idle(4, 1'b0);
    step(1'b1, 8'hA4, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(6, 1'b1);

    // Full chain with simultaneous pop and push
    for (int i = 0; i < 4; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    idle(8, 1'b1);

    // Flush with an input offered in the flush cycle
    for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    idle(6, 1'b1);

    // Asynchronous reset between edges while output is valid
    for (int i = 0; i < 6; i++) step(1'b1, 8'hD0 + 8'(i), 1'b1, 1'b0);
    i_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(o_valid), 32'h0);
    chk("arst_q", 32'(o_q), 32'h0);
    chk("arst_count", 32'(o_count), 32'h0);
    q.delete();
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step(1'b1, 8'h99, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), WIDTH'($urandom),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 63) == 0));
    end
    idle(8, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
